div32x32: RTL and testbench
===========================

Name: div32x32

Overview:
- Sequential 32-bit unsigned divider. It is the inverse-direction companion to the 32x32 multiplier and uses the same control/datapath split.
- Restoring radix-2 algorithm, one quotient bit per clock.
- Operands are latched on a start handshake. Quotient and remainder are returned with a one-cycle done pulse.
- Sits beside the multiplier in the arithmetic unit and is driven by the same sequencing logic.

Parameters:
- WIDTH, 32, operand/result width in bits; the iteration count equals WIDTH.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  request; sampled only when the block is not busy.
- a  input  WIDTH  dividend; latched on the accepting edge.
- b  input  WIDTH  divisor; latched on the accepting edge.
- busy  output  1  high while iterations are in progress.
- done  output  1  one-cycle pulse; result valid.
- quotient  output  WIDTH  registered quotient; held until the next completion.
- remainder  output  WIDTH  registered remainder; held until the next completion.
- div_by_zero  output  1  registered flag for the last completed operation.

Behaviour:
- Reset (reset=0, asynchronous):
  - state goes to IDLE.
  - busy, done, div_by_zero are 0; quotient and remainder are 0.
  - working registers and iteration counter are cleared.
  - Reset mid-operation aborts the operation; no done is produced.
- States: IDLE, RUN, DONE.
- Acceptance: start=1 is accepted at a rising edge when state is IDLE or DONE. Call that edge E0.
  - start in RUN is ignored; no queuing.
  - Operands must be stable only at E0.
- IDLE/DONE with start and b != 0:
  - At E0, latch divisor.
  - Load the working register: rem = 0 (WIDTH+1 bits), quo = a.
  - Clear the counter; go to RUN; busy = 1.
- RUN: at each edge E1..E(WIDTH):
  - Shift {rem, quo} left by 1.
  - trial = rem_shifted - {1'b0, divisor}, computed in WIDTH+1 bits.
  - If trial is non-negative (no borrow): rem = trial and quo[0] = 1. Otherwise rem = rem_shifted and quo[0] = 0.
  - Increment the counter.
  - The WIDTH+1-bit rem is mandatory: a shifted remainder can reach 2*b-1.
- At edge E(WIDTH), i.e. the last iteration:
  - quotient <= final quo; remainder <= final rem[WIDTH-1:0]; div_by_zero <= 0.
  - done <= 1; busy <= 0; state goes to DONE.
  - Total latency: done rises on the 32nd edge after E0.
- DONE lasts one cycle:
  - Next edge: done <= 0.
  - If start=1 on that edge, it is accepted as a new E0. Otherwise go to IDLE.
- Divide by zero (b == 0 at E0):
  - Skip RUN. At E0: quotient <= all ones, remainder <= a, div_by_zero <= 1, done <= 1.
  - Go to DONE; busy stays 0.
- Stability of results:
  - quotient, remainder and div_by_zero change only at a completion edge or at reset.
  - They hold the previous result throughout RUN.
- Arithmetic is unsigned only. No overflow is possible for b != 0.

Decomposition:
- Package div_pkg:
  - state enum (IDLE, RUN, DONE).
  - DIV_WIDTH default constant 32.
  - DBZ_QUOTIENT all-ones constant.
  - counter width constant $clog2(DIV_WIDTH)+1.
- Sub-module div32x32_arith, the datapath:
  - Contains the rem/quo working register, divisor register and trial subtractor.
  - Controls: load, step. Status: final rem/quo.
- Top div32x32 holds the FSM, counter, output registers and handshake.

Test Plan:
- a=100, b=7, start 1 cycle: busy high for 32 cycles, then done pulse of exactly 1 cycle; quotient=14, remainder=2, div_by_zero=0.
- a=32'hFFFFFFFF, b=1: quotient=32'hFFFFFFFF, remainder=0.
- a=32'hFFFFFFFF, b=32'h80000001: quotient=1, remainder=32'h7FFFFFFE. Exercises the 33-bit trial subtract.
- a=5, b=0: done on the edge after start, busy never high; quotient=32'hFFFFFFFF, remainder=5, div_by_zero=1. A following a=9, b=2 clears div_by_zero and gives 4 r 1.
- a=3, b=10, with start re-pulsed with a=50, b=5 during RUN:
  - The second request is ignored; result is quotient=0, remainder=3.
  - start held high in the DONE cycle with a=50, b=5 is accepted; result 10 r 0.
- reset=0 pulsed after 10 RUN iterations:
  - All outputs go to 0 immediately (asynchronously); no done appears.
  - After release, a=1000, b=10 gives quotient=100, remainder=0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DIV_WIDTH = 32;

  // Quotient reported for a zero divisor.
  localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = {DIV_WIDTH{1'b1}};

  // Iteration counter width; wide enough to hold DIV_WIDTH itself.
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

endpackage

// File: rtl/div32x32_arith.sv
// Restoring-division datapath: partial remainder, quotient/dividend shift
// register and divisor, plus the one-bit-per-step trial subtractor.
module div32x32_arith
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_quo_nxt,
  output logic [WIDTH-1:0] o_rem_nxt
);

  // The stored remainder is always below the divisor, so WIDTH bits suffice;
  // the shifted value can reach 2*b-1 and needs WIDTH+1 bits.
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_neg;

  // Trial subtract: with w_shift < 2*b the WIDTH+1-bit result never wraps,
  // so its top bit is a clean sign (set = borrow, restore the remainder).
  always_comb begin
    w_shift   = {r_rem, r_quo[WIDTH-1]};
    w_trial   = w_shift - {1'b0, r_div};
    w_neg     = w_trial[WIDTH];
    o_rem_nxt = w_neg ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
    o_quo_nxt = {r_quo[WIDTH-2:0], ~w_neg};
  end

  // Working registers: load operands on acceptance, advance one bit per step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rem <= '0;
      r_quo <= '0;
      r_div <= '0;
    end else if (i_load) begin
      r_rem <= '0;
      r_quo <= i_a;
      r_div <= i_b;
    end else if (i_step) begin
      r_rem <= o_rem_nxt;
      r_quo <= o_quo_nxt;
    end
  end

endmodule

// File: rtl/div32x32.sv
// Sequential unsigned divider: start/done handshake, iteration control and
// result registers around the restoring-division datapath.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; results hold the last completed operation
// RUN   | one quotient bit per clock, WIDTH iterations; start ignored
// DONE  | one-cycle done pulse; a start here begins the next operation
module div32x32
  import div_pkg::*;
#(
  // Must not exceed DIV_WIDTH: the counter and zero-divisor quotient are sized from it.
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_e             r_state;
  div_state_e             w_state_nxt;
  logic [DIV_CNT_W-1:0]   r_cnt;

  logic                   w_accept;
  logic                   w_b_zero;
  logic                   w_load;
  logic                   w_step;
  logic                   w_last;
  logic [WIDTH-1:0]       w_quo_nxt;
  logic [WIDTH-1:0]       w_rem_nxt;

  assign w_b_zero = (b == '0);
  assign w_step   = (r_state == RUN);
  assign w_last   = w_step && (r_cnt == DIV_CNT_W'(WIDTH - 1));
  assign busy     = (r_state == RUN);
  assign done     = (r_state == DONE);

  // Next-state and handshake decode; IDLE and DONE both accept a new start.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        w_state_nxt = IDLE;
        if (start) begin
          w_accept    = 1'b1;
          w_load      = !w_b_zero;
          w_state_nxt = w_b_zero ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_last) w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Iteration counter: cleared on load, counts completed steps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_cnt <= '0;
    else if (w_load) r_cnt <= '0;
    else if (w_step) r_cnt <= r_cnt + 1'b1;
  end

  // Result registers: updated only on a completion edge (last step or zero divisor).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (w_accept && w_b_zero) begin
      quotient    <= DBZ_QUOTIENT[WIDTH-1:0];
      remainder   <= a;
      div_by_zero <= 1'b1;
    end else if (w_last) begin
      quotient    <= w_quo_nxt;
      remainder   <= w_rem_nxt;
      div_by_zero <= 1'b0;
    end
  end

  div32x32_arith #(.WIDTH(WIDTH)) u_arith (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_step    (w_step),
    .i_a       (a),
    .i_b       (b),
    .o_quo_nxt (w_quo_nxt),
    .o_rem_nxt (w_rem_nxt)
  );

endmodule

// File: tb/tb_div32x32.sv
// Directed testbench for div32x32 with hand-computed expected results.
module tb_div32x32;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_chk = 0;
  int n_err = 0;

  div32x32 dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a request before a rising edge; returns #1 after the accepting edge.
  task automatic issue(input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after E0 until done; also counts cycles with busy high,
  // including the cycle right after E0.
  task automatic wait_done(output int edges, output int busy_cyc);
    edges    = 0;
    busy_cyc = busy ? 1 : 0;
    while (!done && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
      if (busy) busy_cyc++;
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] q, input logic [31:0] r,
                              input logic dz);
    chk({tag, "_q"},   quotient,    q);
    chk({tag, "_r"},   remainder,   r);
    chk({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, dz});
  endtask

  task automatic run_div(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] q, input logic [31:0] r);
    int edges;
    int busy_cyc;
    issue(av, bv);
    chk({tag, "_busy_e0"}, {31'd0, busy}, 32'd1);
    wait_done(edges, busy_cyc);
    chk({tag, "_latency"}, edges, 32);
    chk({tag, "_busy_cyc"}, busy_cyc, 32);
    check_result(tag, q, r, 1'b0);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int edges;
    int busy_cyc;
    int dz_busy;

    reset = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    check_result("rst", 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Basic case, then results must hold through the next RUN.
    run_div("d100_7", 32'd100, 32'd7, 32'd14, 32'd2);
    issue(32'hFFFF_FFFF, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("hold_q_in_run", quotient, 32'd14);
    chk("hold_r_in_run", remainder, 32'd2);
    wait_done(edges, busy_cyc);
    chk("max_by1_latency", edges, 32 - 5);
    check_result("max_by1", 32'hFFFF_FFFF, 32'd0, 1'b0);

    run_div("wide_trial", 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE);

    // Divide by zero: completes at E0, busy never rises.
    @(posedge clk);
    issue(32'd5, 32'd0);
    chk("dbz_done_e0", {31'd0, done}, 32'd1);
    chk("dbz_busy", {31'd0, busy}, 32'd0);
    check_result("dbz", 32'hFFFF_FFFF, 32'd5, 1'b1);
    dz_busy = 0;
    @(posedge clk);
    #1;
    if (busy) dz_busy++;
    chk("dbz_busy_after", dz_busy, 0);
    chk("dbz_done_pulse", {31'd0, done}, 32'd0);
    run_div("d9_2", 32'd9, 32'd2, 32'd4, 32'd1);

    // Start re-pulsed during RUN is ignored.
    issue(32'd3, 32'd10);
    repeat (5) @(posedge clk);
    #1;
    a     = 32'd50;
    b     = 32'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 32'd3;
    b     = 32'd10;
    wait_done(edges, busy_cyc);
    chk("ignore_latency", edges, 32 - 6);
    check_result("ignore", 32'd0, 32'd3, 1'b0);

    // Start held in the DONE cycle is accepted back-to-back.
    a     = 32'd50;
    b     = 32'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    chk("b2b_done_low", {31'd0, done}, 32'd0);
    wait_done(edges, busy_cyc);
    chk("b2b_latency", edges, 32);
    check_result("b2b", 32'd10, 32'd0, 1'b0);

    // Asynchronous reset after 10 iterations aborts without done.
    @(posedge clk);
    issue(32'd77, 32'd3);
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    check_result("arst", 32'd0, 32'd0, 1'b0);
    edges = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done || busy) edges++;
    end
    chk("arst_quiet", edges, 0);
    @(negedge clk);
    reset = 1'b1;
    edges = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done) edges++;
    end
    chk("arst_no_done", edges, 0);
    run_div("d1000_10", 32'd1000, 32'd10, 32'd100, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
